// File: rtl/uart_tx_fifo_if.sv
// Producer-side and transmitter-side signals of the UART TX byte buffer.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  clr_ovf;
    logic                  tx_ready;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  tx_req;
    logic [7:0]            tx_data;
    logic                  busy;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_ready,
        input  full, empty, level, overflow,
        input  tx_req, tx_data, busy
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_ready,
        output full, empty, level, overflow,
        output tx_req, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through REQ/DATA/READY,
// with a one-byte holding register so the next frame is prefetched.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t              r_state;
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [DEPTH_LOG2:0] r_level;
    logic [7:0]          r_mem [DEPTH];
    logic [7:0]          r_tx_data;
    logic                r_tx_req;
    logic                r_ovf;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_wr    = bus.wr_en && !w_full;
    // Pop only sees bytes already stored: no fall-through on an empty FIFO.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + PTR_ONE;
                2'b01:   r_level <= r_level - PTR_ONE;
                default: r_level <= r_level;
            endcase
            if (bus.wr_en && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_req <= 1'b1;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        r_tx_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_ovf;
    assign bus.tx_req   = r_tx_req;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = !(w_empty && (r_state == S_IDLE) && bus.tx_ready);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: bytes accepted into the FIFO are queued as expected
// transmitter traffic; a monitor checks every REQ&&READY handshake.
module tb_uart_tx_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  logic [7:0] mq[$];
  bit hv;
  int hage;
  bit movf;
  int tx_cnt;
  bit force_low;
  bit pulse_rdy;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp,
               $time);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] e;
    if (!rst && bus.tx_req && bus.tx_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL tx_accept: got byte %02h expected none", bus.tx_data);
      end else begin
        e = sb.pop_front();
        if (bus.tx_data !== e) begin
          fails++;
          $display("FAIL tx_accept: got %02h expected %02h", bus.tx_data, e);
        end
      end
    end
  end

  // Entered at a falling edge; leaves at the next falling edge.
  task automatic step(input bit we, input logic [7:0] d, input bit clr);
    bit rdy, full_m, empty_m, acc, pop, wok;
    if (pulse_rdy) rdy = 1'b1;
    else if (force_low) rdy = 1'b0;
    else rdy = (tx_cnt == 0);
    bus.tx_ready = rdy;
    bus.wr_en = we;
    bus.wr_data = d;
    bus.clr_ovf = clr;
    #1;
    full_m = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    chk("level", 32'(bus.level), 32'(mq.size()));
    chk("full", 32'(bus.full), 32'(full_m));
    chk("empty", 32'(bus.empty), 32'(empty_m));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("tx_req", 32'(bus.tx_req), 32'(hv && hage >= 1));
    chk("busy", 32'(bus.busy), 32'(!(empty_m && !hv && rdy)));
    acc = hv && hage >= 1 && rdy;
    pop = !hv && !empty_m;
    wok = we && !full_m;
    if (we && full_m) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (acc) begin
      hv = 1'b0;
      tx_cnt = $urandom_range(12, 2);
    end else if (tx_cnt > 0) begin
      tx_cnt--;
    end
    if (pop) begin
      hv = 1'b1;
      hage = 0;
      void'(mq.pop_front());
    end else if (hv) begin
      hage = 1;
    end
    if (wok) begin
      mq.push_back(d);
      sb.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.tx_ready = (tx_cnt == 0);
    rst = 1'b1;
    #1;
    chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    mq.delete();
    sb.delete();
    hv = 1'b0;
    hage = 0;
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Single byte with an idle transmitter
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_req_low", 32'(bus.tx_req), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_req_high", 32'(bus.tx_req), 32'd1);
    chk("lat_data", 32'(bus.tx_data), 32'h41);
    repeat (4) step(1'b0, 8'h00, 1'b0);

    // Burst "Hello"
    step(1'b1, 8'h48, 1'b0);
    step(1'b1, 8'h65, 1'b0);
    step(1'b1, 8'h6c, 1'b0);
    step(1'b1, 8'h6c, 1'b0);
    step(1'b1, 8'h6f, 1'b0);
    repeat (80) step(1'b0, 8'h00, 1'b0);
    chk("hello_drained", 32'(sb.size()), 32'd0);

    // Fill with the transmitter stalled
    force_low = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    chk("fill_ovf", 32'(bus.overflow), 32'd1);

    // Overflow clear, then clear racing an overflowing write
    step(1'b0, 8'h00, 1'b1);
    chk("clr_alone", 32'(bus.overflow), 32'd0);
    step(1'b1, 8'hee, 1'b1);
    chk("clr_vs_set", 32'(bus.overflow), 32'd1);

    // Write coinciding with a pop at LEVEL 16, then at LEVEL 8
    pulse_rdy = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    pulse_rdy = 1'b0;
    step(1'b1, 8'hc3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pop_at_full_level", 32'(bus.level), 32'd15);
    chk("pop_at_full_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      pulse_rdy = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      pulse_rdy = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    chk("mid_level_pre", 32'(bus.level), 32'd8);
    pulse_rdy = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    pulse_rdy = 1'b0;
    step(1'b1, 8'h3c, 1'b0);
    chk("mid_level_post", 32'(bus.level), 32'd8);
    force_low = 1'b0;
    for (int i = 0; i < 400 && sb.size() != 0; i++)
      step(1'b0, 8'h00, 1'b0);
    chk("fill_drained", 32'(sb.size()), 32'd0);

    // Reset while a frame is waiting in S_SEND with 3 bytes queued
    force_low = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'(8'h10 + i), 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_req", 32'(bus.tx_req), 32'd1);
    chk("pre_rst_level", 32'(bus.level), 32'd3);
    force_low = 1'b0;
    tx_cnt = 5;
    do_reset();
    step(1'b1, 8'h5a, 1'b0);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_sent", 32'(sb.size()), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(99, 0) < 35), 8'($urandom),
           ($urandom_range(99, 0) < 3));
    for (int i = 0; i < 600 && sb.size() != 0; i++)
      step(1'b0, 8'h00, 1'b0);
    chk("random_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer that sits directly upstream of the UART transmitter (uartTx). It accepts bytes from a producer with a single-cycle write strobe and stores them in a circular FIFO. It then feeds the transmitter one byte at a time through that block's REQ/DATA/READY handshake. This lets bursty producers, such as message generators or debug dumpers, queue strings without polling the transmitter.

Parameters:
DEPTH_LOG2, 4, log2 of the FIFO depth; DEPTH = 2^DEPTH_LOG2 entries of 8 bits.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  asynchronous, active-high reset.
WR_EN  in  1  producer write strobe; one byte per cycle it is high.
WR_DATA  in  8  byte to enqueue.
FULL  out  1  FIFO holds DEPTH entries.
EMPTY  out  1  FIFO holds 0 entries.
LEVEL  out  DEPTH_LOG2+1  number of entries in the FIFO, 0..DEPTH; excludes the holding register.
OVERFLOW  out  1  sticky flag: a write was attempted while FULL.
CLR_OVF  in  1  clears OVERFLOW.
TX_READY  in  1  from the transmitter READY output; high when it can accept a byte.
TX_REQ  out  1  to the transmitter REQ input.
TX_DATA  out  8  to the transmitter DATA input.
BUSY  out  1  high unless FIFO is empty, the FSM is in S_IDLE, and TX_READY is high.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is asynchronous, active-high.
- Reset state:
  - read and write pointers = 0; LEVEL = 0; EMPTY = 1; FULL = 0; OVERFLOW = 0.
  - TX_REQ = 0; TX_DATA = 8'h00; FSM in S_IDLE.
  - BUSY follows its definition; it is high if TX_READY is low.
- All outputs are registered, except FULL, EMPTY and BUSY, which are decoded from registered state.
- Transmitter contract: the transmitter latches DATA on the edge where REQ && READY. READY drops the next cycle and stays low for the whole frame of about 10 bit times. The transmitter has no reset.
- FIFO:
  - Pointers are DEPTH_LOG2+1 bits wide; the address is the low DEPTH_LOG2 bits, and the pointers wrap naturally.
  - FULL when the pointers differ only in the MSB. EMPTY when the pointers are equal.
  - Write: when WR_EN && !FULL, store WR_DATA at the write pointer and increment it.
  - Write while FULL: data is dropped, pointers are unchanged, and OVERFLOW is set.
  - A write and a pop in the same cycle are both performed; LEVEL is unchanged.
  - A write while EMPTY in a cycle where the FSM wants to pop: no pop that cycle; the byte becomes visible next cycle. There is no fall-through.
  - A write while FULL in the same cycle as a pop is still rejected, because FULL is evaluated before the pop.
  - OVERFLOW clear: CLR_OVF clears OVERFLOW. If CLR_OVF and an overflowing write occur in the same cycle, set wins.
- FSM, 3 states:
  - S_IDLE: if !EMPTY, load TX_DATA from the head, increment the read pointer (pop), and go to S_LOAD. Otherwise stay.
  - S_LOAD: set TX_REQ = 1 and go to S_SEND. This gives one cycle of data setup before REQ.
  - S_SEND: TX_REQ is held at 1. On an edge where TX_READY is high, the transmitter accepts the byte; set TX_REQ = 0 and go to S_IDLE. While TX_READY is low, stay in S_SEND with TX_REQ and TX_DATA stable.
- Prefetch: the FSM returns to S_IDLE while the transmitter is still sending. The next byte is popped into TX_DATA during that frame, so back-to-back frames leave no idle gap beyond the transmitter's own turnaround.
- Latency: a byte written to an empty FIFO with an idle transmitter is accepted 3 edges after the write edge: pop, REQ rise, accept.
- Single transfer per byte: TX_REQ is never high on the edge following an accept edge.
- Reset mid-frame: the FIFO contents and any byte in the holding register are discarded. The transmitter finishes its current frame. After reset the FSM waits for a new FIFO byte and then waits in S_SEND for TX_READY, so no byte is corrupted or sent twice.

Test Plan:
1. Reset, then write 8'h41 once with TX_READY held at 1 → TX_REQ rises 2 edges after the write with TX_DATA = 8'h41; it falls after exactly 1 accept edge; EMPTY = 1 and BUSY = 0 afterwards.
2. Write "Hello" (5 bytes in 5 consecutive cycles) against a real uartTx with pTop = 3 → the serial line carries 5 frames of 10 bits each, LSB first, bytes in order, with no extra idle bit times between frames; LEVEL peaks at 4.
3. With TX_READY forced to 0, write DEPTH+2 = 18 bytes → FULL = 1 after 17 writes (16 in the FIFO plus 1 already popped to the holding register); later writes are dropped; OVERFLOW = 1; LEVEL = 16. Release TX_READY → exactly 17 bytes are delivered in order.
4. Pulse CLR_OVF alone → OVERFLOW = 0. Pulse CLR_OVF while writing to a full FIFO → OVERFLOW stays 1.
5. With LEVEL = 16, write and pop in the same cycle (TX_READY pulse in S_IDLE) → the write is rejected because FULL is evaluated first; LEVEL = 15 and OVERFLOW = 1. Repeat at LEVEL = 8 → LEVEL stays 8.
6. Assert RST for 1 cycle while in S_SEND with 3 bytes queued → TX_REQ drops immediately (asynchronously), LEVEL = 0, EMPTY = 1. A new byte written after reset is sent exactly once after the transmitter's READY returns.
